// File: rtl/spi_slave_if.sv
// Bundle of parallel-side and serial-side signals of the SPI slave.
// The slave modport is the block's view; master is the view of whoever
// drives the serial lines and consumes the received words.
interface spi_slave_if #(
  parameter int reg_width     = 8,
  parameter int counter_width = $clog2(reg_width)
);
  logic [counter_width:0] t_size;
  logic [reg_width-1:0]   tx_data;
  logic                   tx_load;
  logic                   spi_clk;
  logic                   cs;
  logic                   mosi;
  logic                   miso;
  logic [reg_width-1:0]   rx_data;
  logic                   rx_valid;
  logic                   busy;
  logic                   frame_err;

  modport slave (
    input  t_size, tx_data, tx_load, spi_clk, cs, mosi,
    output miso, rx_data, rx_valid, busy, frame_err
  );

  modport master (
    output t_size, tx_data, tx_load, spi_clk, cs, mosi,
    input  miso, rx_data, rx_valid, busy, frame_err
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, cs active-low, fully in the sys_clk domain.
// spi_clk/cs/mosi are oversampled; frames of 1..reg_width bits are
// deserialised into rx_data and a preloaded word is shifted out on miso.
module spi_slave #(
  parameter int reg_width     = 8,
  parameter int counter_width = $clog2(reg_width)
) (
  input  logic       sys_clk,
  input  logic       rst,
  spi_slave_if.slave bus
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [counter_width:0] cnt_zero = '0;
  localparam logic [counter_width:0] cnt_one  = (counter_width + 1)'(1);
  localparam logic [counter_width:0] n_max    = (counter_width + 1)'(reg_width);
  localparam logic [reg_width-1:0]   lsb_one  = reg_width'(1);

  // Synchronizer chains; stage 3 exists only for edge detection.
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic cs_s1_q,   cs_s2_q,   cs_s3_q;
  logic mosi_s1_q, mosi_s2_q;
  logic [2:0] sync_ok_q;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [0:0]             state_q, state_d;
  logic [counter_width:0] cnt_q, cnt_d;
  logic [counter_width:0] n_q, n_d;
  logic [counter_width:0] n_new;
  logic [counter_width:0] cnt_inc;
  logic [reg_width-1:0]   tx_buf_q, tx_buf_d;
  logic [reg_width-1:0]   tx_sh_q, tx_sh_d;
  logic [reg_width-2:0]   rx_sh_q, rx_sh_d;
  logic [reg_width-1:0]   rx_next;
  logic [reg_width-1:0]   rx_data_q, rx_data_d;
  logic                   miso_q, miso_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   start_frame;
  logic                   go_idle;

  // Selects bit idx of v without an index-width mismatch.
  function automatic logic bit_at(input logic [reg_width-1:0] v,
                                  input logic [counter_width:0] idx);
    return |((v >> idx) & lsb_one);
  endfunction

  // Input synchronizers. Reset loads the idle bus levels; sync_ok_q keeps
  // edge detection off until stage 3 holds a real sample, so a cs that is
  // already low when reset releases does not look like a falling edge.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state is updated with <= only, so every flop samples
    // the pre-edge value of its neighbours and the chain shifts by one stage.
    if (rst) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_s3_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      sync_ok_q <= '0;
    end else begin
      sclk_s1_q <= bus.spi_clk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      cs_s1_q   <= bus.cs;
      cs_s2_q   <= cs_s1_q;
      cs_s3_q   <= cs_s2_q;
      mosi_s1_q <= bus.mosi;
      mosi_s2_q <= mosi_s1_q;
      sync_ok_q <= {sync_ok_q[1:0], 1'b1};
    end
  end

  // Edge detection on the synchronized lines; mosi_s2_q is the same stage
  // as sclk_s2_q, so it is the data bit belonging to a detected rise.
  always_comb begin
    sclk_rise = sync_ok_q[2] &  sclk_s2_q & ~sclk_s3_q;
    sclk_fall = sync_ok_q[2] & ~sclk_s2_q &  sclk_s3_q;
    cs_fall   = sync_ok_q[2] & ~cs_s2_q   &  cs_s3_q;
    cs_rise   = sync_ok_q[2] &  cs_s2_q   & ~cs_s3_q;
  end

  // Effective frame length and shift helpers.
  always_comb begin
    n_new   = ((bus.t_size == cnt_zero) || (bus.t_size > n_max)) ? n_max : bus.t_size;
    cnt_inc = cnt_q + cnt_one;
    rx_next = {rx_sh_q, mosi_s2_q};
  end

  // Next-state logic for the frame state machine and its datapath.
  always_comb begin
    // NOTE: every _d gets a default before the case, so no path can leave a
    // variable unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    start_frame = 1'b0;
    go_idle     = 1'b0;
    tx_buf_d    = bus.tx_load ? bus.tx_data : tx_buf_q;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          start_frame = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (sclk_rise && (cnt_inc == n_q)) begin
          // Completing bit wins over a simultaneous cs rise.
          rx_data_d  = rx_next;
          rx_valid_d = 1'b1;
          if (cs_rise) begin
            go_idle = 1'b1;
          end else begin
            start_frame = 1'b1;
          end
        end else if (cs_rise) begin
          frame_err_d = (cnt_q != cnt_zero);
          go_idle     = 1'b1;
        end else if (sclk_rise) begin
          rx_sh_d = rx_next[reg_width-2:0];
          cnt_d   = cnt_inc;
        end else if (sclk_fall && (cnt_q < n_q)) begin
          miso_d = bit_at(tx_sh_q, n_q - cnt_q - cnt_one);
        end
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase

    if (go_idle) begin
      state_d = ST_IDLE;
      cnt_d   = cnt_zero;
      miso_d  = 1'b0;
    end

    // A new frame snapshots tx_buf and t_size and presents its MSB at once,
    // ready for the master's first rising edge.
    if (start_frame) begin
      state_d = ST_ACTIVE;
      cnt_d   = cnt_zero;
      n_d     = n_new;
      tx_sh_d = tx_buf_q;
      rx_sh_d = '0;
      miso_d  = bit_at(tx_buf_q, n_new - cnt_one);
    end
  end

  // State and datapath registers; reset abandons any frame silently.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= cnt_zero;
      n_q         <= n_max;
      tx_buf_q    <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      tx_buf_q    <= tx_buf_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.miso      = miso_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed cases followed by random
// frames, all checked against a word-level model of the SPI transaction.
module tb_spi_slave;

  logic sys_clk;
  logic rst;

  spi_slave_if #(.reg_width(8)) bus ();

  spi_slave #(.reg_width(8)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: current tx buffer and the last completed word.
  logic [7:0] model_tx = 8'h00;
  logic [7:0] last_rx  = 8'h00;
  int         exp_err  = 0;

  // Observed pulses, sampled on the falling sys_clk edge.
  logic [7:0] rx_q[$];
  int         err_cnt = 0;

  always @(negedge sys_clk) begin
    if (!rst) begin
      if (bus.rx_valid === 1'b1) rx_q.push_back(bus.rx_data);
      if (bus.frame_err === 1'b1) err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_n(input logic [3:0] ts);
    return (ts == 4'd0 || ts > 4'd8) ? 8 : int'(ts);
  endfunction

  function automatic logic [7:0] mask(input int n);
    return 8'((32'd1 << n) - 1);
  endfunction

  function automatic logic [7:0] pop_rx();
    logic [7:0] v;
    v = 8'hxx;
    if (rx_q.size() > 0) v = rx_q.pop_front();
    return v;
  endfunction

  task automatic tx_load_pulse(input logic [7:0] v);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    @(negedge sys_clk);
    bus.tx_load = 1'b0;
    model_tx = v;
  endtask

  task automatic cs_low(input int h);
    bus.cs = 1'b0;
    repeat (h) @(negedge sys_clk);
  endtask

  task automatic cs_high(input int h);
    repeat (h) @(negedge sys_clk);
    bus.cs = 1'b1;
    repeat (h + 4) @(negedge sys_clk);
  endtask

  // Master side of nb bits: drive mosi while spi_clk is low, sample miso
  // just before raising spi_clk (mode 0). Optionally pulse tx_load after
  // bit load_at, or raise cs together with the last rising edge.
  task automatic spi_bits(input logic [7:0] word, input int nb, input int h,
                          input int load_at, input logic [7:0] load_val,
                          input bit end_cs, output logic [7:0] got);
    got = '0;
    for (int i = nb - 1; i >= 0; i--) begin
      bus.mosi = word[i];
      repeat (h) @(negedge sys_clk);
      got = {got[6:0], bus.miso};
      bus.spi_clk = 1'b1;
      if (end_cs && i == 0) bus.cs = 1'b1;
      repeat (h) @(negedge sys_clk);
      bus.spi_clk = 1'b0;
      if (nb - 1 - i == load_at) tx_load_pulse(load_val);
    end
  endtask

  // One complete frame with all its checks against the model.
  task automatic run_frame(input string tag, input logic [3:0] ts, input logic [7:0] word,
                           input int h, input bit end_cs);
    int n;
    logic [7:0] m, exp_miso, got;
    bus.t_size = ts;
    n = eff_n(ts);
    m = mask(n);
    exp_miso = model_tx & m;
    cs_low(h);
    check({tag, "_busy_hi"}, 32'(bus.busy), 32'd1);
    spi_bits(word, n, h, -1, 8'h00, end_cs, got);
    if (end_cs) repeat (h + 4) @(negedge sys_clk);
    else cs_high(h);
    last_rx = word & m;
    check({tag, "_miso"}, 32'(got), 32'(exp_miso));
    check({tag, "_rxcnt"}, 32'(rx_q.size()), 32'd1);
    check({tag, "_rxdata"}, 32'(pop_rx()), 32'(last_rx));
    check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
    check({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
    rx_q.delete();
  endtask

  initial begin
    logic [7:0] got, got2, old_tx, w;
    logic [3:0] ts;
    int h;

    rst = 1'b1;
    bus.cs = 1'b0;
    bus.spi_clk = 1'b0;
    bus.mosi = 1'b0;
    bus.t_size = 4'd8;
    bus.tx_data = 8'h00;
    bus.tx_load = 1'b0;

    // Reset held with cs low and spi_clk toggling.
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < 6; i++) begin
      bus.spi_clk = ~bus.spi_clk;
      bus.mosi = ~bus.mosi;
      repeat (3) @(negedge sys_clk);
    end
    check("reset_outputs", 32'({bus.miso, bus.rx_data, bus.rx_valid, bus.busy, bus.frame_err}), 32'd0);

    // Release with cs still low: no frame may start.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.spi_clk = ~bus.spi_clk;
      bus.mosi = 1'b1;
      repeat (4) @(negedge sys_clk);
    end
    check("no_start_busy", 32'(bus.busy), 32'd0);
    check("no_start_rx", 32'(rx_q.size()), 32'd0);
    bus.spi_clk = 1'b0;
    bus.cs = 1'b1;
    repeat (8) @(negedge sys_clk);

    // Full byte.
    tx_load_pulse(8'hA5);
    run_frame("full_byte", 4'd8, 8'h55, 4, 1'b0);

    // Short frame.
    tx_load_pulse(8'h06);
    run_frame("short3", 4'd3, 8'h05, 4, 1'b0);

    // Out-of-range lengths behave as 8 bits.
    tx_load_pulse(8'h3E);
    run_frame("tsize0", 4'd0, 8'hC9, 3, 1'b0);
    run_frame("tsize15", 4'hF, 8'h71, 5, 1'b0);

    // Back-to-back frames with a tx_load during the first one.
    old_tx = model_tx;
    bus.t_size = 4'd8;
    cs_low(4);
    spi_bits(8'hAA, 8, 4, 3, 8'hF0, 1'b0, got);
    spi_bits(8'h3C, 8, 4, -1, 8'h00, 1'b0, got2);
    cs_high(4);
    check("b2b_miso1", 32'(got), 32'(old_tx));
    check("b2b_miso2", 32'(got2), 32'h0F0);
    check("b2b_rxcnt", 32'(rx_q.size()), 32'd2);
    check("b2b_rx1", 32'(pop_rx()), 32'h0AA);
    check("b2b_rx2", 32'(pop_rx()), 32'h03C);
    check("b2b_err", 32'(err_cnt), 32'(exp_err));
    last_rx = 8'h3C;
    rx_q.delete();

    // Abort after 5 of 8 bits.
    tx_load_pulse(8'hB6);
    cs_low(4);
    spi_bits(8'h1F, 5, 4, -1, 8'h00, 1'b0, got);
    cs_high(4);
    exp_err++;
    check("abort_miso", 32'(got), 32'(model_tx >> 3));
    check("abort_err", 32'(err_cnt), 32'(exp_err));
    check("abort_rxcnt", 32'(rx_q.size()), 32'd0);
    check("abort_rxdata", 32'(bus.rx_data), 32'(last_rx));
    rx_q.delete();
    run_frame("after_abort", 4'd8, 8'h96, 4, 1'b0);

    // Last rising edge and cs rise seen on the same cycle: frame completes.
    tx_load_pulse(8'h5A);
    run_frame("same_cycle", 4'd8, 8'hE1, 3, 1'b1);
    bus.cs = 1'b1;
    repeat (6) @(negedge sys_clk);

    // Reset in the middle of a frame is silent.
    cs_low(4);
    spi_bits(8'hFF, 3, 4, -1, 8'h00, 1'b0, got);
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    repeat (6) @(negedge sys_clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_err", 32'(err_cnt), 32'(exp_err));
    check("midrst_rxdata", 32'(bus.rx_data), 32'd0);
    bus.cs = 1'b1;
    repeat (8) @(negedge sys_clk);
    model_tx = 8'h00;
    last_rx = 8'h00;
    rx_q.delete();

    // Random frames.
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(1, 0) == 1) tx_load_pulse(8'($urandom));
      ts = 4'($urandom_range(15, 0));
      w = 8'($urandom);
      h = int'($urandom_range(6, 3));
      run_frame($sformatf("rand%0d", k), ts, w, h, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
